// File: rtl/dp_mem_port_arbiter_if.sv
// Requester-side and DP_MEM-side bus of one arbiter instance.
// slave = arbiter view, master = environment (requesters + memory) view.
interface dp_mem_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 8,
    parameter int DW      = 8
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_op;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic                  mem_valid;
    logic                  mem_ready;
    logic                  mem_op;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, mem_valid, mem_op, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_valid, mem_op, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dp_mem_port_arbiter.sv
// Round-robin arbiter sharing one DP_MEM port between NUM_REQ requesters,
// with read-return routing through a READ_LAT-deep in-flight pipe.
//
// state | meaning
// IDLE  | output register empty, mem_valid=0
// ISSUE | output register holds a request, mem_valid=1
module dp_mem_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int READ_LAT = 1
) (
    input logic                  clk,
    input logic                  rstn,
    dp_mem_port_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win;
    logic          found;
    logic          grant;
    logic          accept;

    logic          mem_op_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [IW-1:0] mem_id_q;

    logic [IW:0]   pipe [READ_LAT];
    logic          pipe_read;
    logic [IW-1:0] pipe_id;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // rstn gates grant so req_ready stays low while reset is held
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (found && rstn) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    if (found && rstn) grant     = 1'b1;
                    else               state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant) bus.req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_op_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_id_q    <= '0;
            rr_ptr      <= '0;
        end else if (grant) begin
            mem_op_q    <= bus.req_op[win];
            mem_addr_q  <= bus.req_addr[int'(win)*AW +: AW];
            mem_wdata_q <= bus.req_wdata[int'(win)*DW +: DW];
            mem_id_q    <= win;
            rr_ptr      <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    assign bus.mem_valid = (state == ISSUE);
    assign bus.mem_op    = mem_op_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign accept        = bus.mem_valid & bus.mem_ready;

    // Slot 0 takes the accept of this edge; the last slot lines up with rd_data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {accept & ~mem_op_q, mem_id_q};
            for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign pipe_read = pipe[READ_LAT-1][IW];
    assign pipe_id   = pipe[READ_LAT-1][IW-1:0];

    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_rdata = '0;
        if (pipe_read) begin
            bus.rsp_valid[pipe_id] = 1'b1;
            bus.rsp_rdata          = bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_dp_mem_port_arbiter.sv
// Bench for dp_mem_port_arbiter: READ_LAT=1 and READ_LAT=3 instances share
// stimulus; a transaction-level model predicts grants, port contents and responses.
module tb_dp_mem_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    dp_mem_port_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) b1 ();
    dp_mem_port_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) b3 ();

    dp_mem_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .READ_LAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(b1));
    dp_mem_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .READ_LAT(3)) dut3 (
        .clk(clk), .rstn(rstn), .bus(b3));

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    typedef struct {
        logic [N-1:0]  rv;
        logic [N-1:0]  op;
        logic          mr;
        logic [N-1:0]  e_rdy;
        logic          e_mv;
        logic [N-1:0]  e_rsp;
        logic [DW-1:0] e_rd;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0]  rv;
    logic [N-1:0]  op;
    logic [AW-1:0] addr [N];
    logic [DW-1:0] wd   [N];
    logic          mr;

    // memory behind both ports, plus per-latency read-data delay lines
    logic [DW-1:0] mem [256];
    logic [DW-1:0] line1;
    logic [DW-1:0] line3 [3];

    // reference model: one outstanding slot, rotating priority pointer
    bit            slot_full;
    logic          slot_op;
    logic [AW-1:0] slot_addr;
    logic [DW-1:0] slot_wd;
    int            slot_id;
    int            ptr;
    rsp_t          q1[$];
    rsp_t          q3[$];
    int            cyc;

    logic [N-1:0]  s_rdy1, s_rsp1, s_rsp3;
    logic          s_mv1;
    logic [AW-1:0] s_ma1;
    logic [DW-1:0] s_mw1, s_rd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            b1.req_addr[i*AW +: AW]  = addr[i];
            b3.req_addr[i*AW +: AW]  = addr[i];
            b1.req_wdata[i*DW +: DW] = wd[i];
            b3.req_wdata[i*DW +: DW] = wd[i];
        end
        b1.req_valid = rv;   b3.req_valid = rv;
        b1.req_op    = op;   b3.req_op    = op;
        b1.mem_ready = mr;   b3.mem_ready = mr;
        b1.mem_rdata = line1;
        b3.mem_rdata = line3[2];
    endtask

    task automatic check_inst(input string tag,
                              input logic [N-1:0] rdy, input logic mv, input logic mop,
                              input logic [AW-1:0] ma, input logic [DW-1:0] mw,
                              input logic [N-1:0] rsv, input logic [DW-1:0] rsd,
                              input logic [N-1:0] erdy, input bit ersp,
                              input int eid, input logic [DW-1:0] ed);
        logic [N-1:0] ersv;
        ersv = ersp ? N'(1 << eid) : '0;
        chk({tag, "_req_ready"}, 32'(rdy), 32'(erdy));
        chk({tag, "_mem_valid"}, 32'(mv), 32'(slot_full));
        if (slot_full) begin
            chk({tag, "_mem_op"},    32'(mop), 32'(slot_op));
            chk({tag, "_mem_addr"},  32'(ma),  32'(slot_addr));
            chk({tag, "_mem_wdata"}, 32'(mw),  32'(slot_wd));
        end
        chk({tag, "_rsp_valid"}, 32'(rsv), 32'(ersv));
        chk({tag, "_rsp_rdata"}, 32'(rsd), ersp ? 32'(ed) : 32'd0);
    endtask

    task automatic step();
        bit            grant = 0;
        int            w = 0;
        bit            e1 = 0;
        bit            e3 = 0;
        rsp_t          f1;
        rsp_t          f3;
        bit            acc;
        logic [DW-1:0] rd_new;
        f1 = '{0, '0, 0};
        f3 = f1;
        drive();
        #1;
        if (!slot_full || mr) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (ptr + k) % N;
                if (!grant && rv[i]) begin
                    grant = 1;
                    w     = i;
                end
            end
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin e1 = 1; f1 = q1.pop_front(); end
        if (q3.size() > 0 && q3[0].due == cyc) begin e3 = 1; f3 = q3.pop_front(); end
        s_rdy1 = b1.req_ready; s_mv1 = b1.mem_valid; s_ma1 = b1.mem_addr;
        s_mw1  = b1.mem_wdata; s_rsp1 = b1.rsp_valid; s_rd1 = b1.rsp_rdata;
        s_rsp3 = b3.rsp_valid;
        check_inst("L1", b1.req_ready, b1.mem_valid, b1.mem_op, b1.mem_addr, b1.mem_wdata,
                   b1.rsp_valid, b1.rsp_rdata, grant ? N'(1 << w) : '0, e1, f1.id, f1.data);
        check_inst("L3", b3.req_ready, b3.mem_valid, b3.mem_op, b3.mem_addr, b3.mem_wdata,
                   b3.rsp_valid, b3.rsp_rdata, grant ? N'(1 << w) : '0, e3, f3.id, f3.data);
        acc    = slot_full && mr;
        rd_new = '0;
        if (acc) begin
            if (slot_op) mem[slot_addr] = slot_wd;
            else begin
                rd_new = mem[slot_addr];
                q1.push_back('{slot_id, rd_new, cyc + 1});
                q3.push_back('{slot_id, rd_new, cyc + 3});
            end
        end
        line3[2] = line3[1];
        line3[1] = line3[0];
        line3[0] = rd_new;
        line1    = rd_new;
        if (grant) begin
            slot_full = 1;
            slot_op   = op[w];
            slot_addr = addr[w];
            slot_wd   = wd[w];
            slot_id   = w;
            ptr       = (w + 1) % N;
        end else if (acc) begin
            slot_full = 0;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("rst_L1_mem_valid", 32'(b1.mem_valid), 0);
        chk("rst_L1_mem_op",    32'(b1.mem_op),    0);
        chk("rst_L1_mem_addr",  32'(b1.mem_addr),  0);
        chk("rst_L1_mem_wdata", 32'(b1.mem_wdata), 0);
        chk("rst_L1_req_ready", 32'(b1.req_ready), 0);
        chk("rst_L1_rsp_valid", 32'(b1.rsp_valid), 0);
        chk("rst_L1_rsp_rdata", 32'(b1.rsp_rdata), 0);
        chk("rst_L3_mem_valid", 32'(b3.mem_valid), 0);
        chk("rst_L3_req_ready", 32'(b3.req_ready), 0);
        chk("rst_L3_rsp_valid", 32'(b3.rsp_valid), 0);
        slot_full = 0;
        ptr       = 0;
        q1.delete();
        q3.delete();
        line1 = '0;
        for (int i = 0; i < 3; i++) line3[i] = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        rv = '0;
        mr = 1'b1;
        repeat (n) step();
    endtask

    vec_t tbl [16];

    initial begin
        int first_acc;
        int first_rsp;
        int pulses;

        tbl[0]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 4'b0000, 8'h00};
        tbl[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 8'h5A};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};
        tbl[4]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'b0000, 8'h00};
        tbl[5]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0000, 8'h00};
        tbl[6]  = '{4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 4'b0001, 8'hA1};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1000, 8'hB3};
        tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 4'b0000, 8'h00};
        tbl[10] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0000, 8'h00};
        tbl[11] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0000, 8'h00};
        tbl[12] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'b0000, 8'h00};
        tbl[13] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0000, 8'h00};
        tbl[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00};
        tbl[15] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 8'h00};

        for (int a = 0; a < 256; a++) mem[a] = 8'(a * 7 + 3);
        mem[8'h10] = 8'h5A;
        mem[8'h01] = 8'hA1;
        mem[8'h03] = 8'hB3;
        addr[0] = 8'h01; addr[1] = 8'h02; addr[2] = 8'h10; addr[3] = 8'h03;
        for (int i = 0; i < N; i++) wd[i] = 8'(8'hC0 + i);
        rv = '0; op = '0; mr = 1'b1;
        slot_full = 0; slot_op = 0; slot_addr = '0; slot_wd = '0; slot_id = 0;
        ptr = 0; cyc = 0;
        line1 = '0;
        for (int i = 0; i < 3; i++) line3[i] = '0;
        drive();

        @(negedge clk);
        do_reset();

        // single read, mixed back-to-back, round robin
        for (int r = 0; r < 16; r++) begin
            rv = tbl[r].rv;
            op = tbl[r].op;
            mr = tbl[r].mr;
            step();
            chk($sformatf("tbl%0d_req_ready", r), 32'(s_rdy1), 32'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d_mem_valid", r), 32'(s_mv1),  32'(tbl[r].e_mv));
            chk($sformatf("tbl%0d_rsp_valid", r), 32'(s_rsp1), 32'(tbl[r].e_rsp));
            chk($sformatf("tbl%0d_rsp_rdata", r), 32'(s_rd1),  32'(tbl[r].e_rd));
        end

        // backpressure: write held stable for 5 stalled cycles
        idle_cycles(3);
        addr[1] = 8'h33; wd[1] = 8'hC3; op = 4'b0010; rv = 4'b0010; mr = 1'b1;
        step();
        chk("bp_grant", 32'(s_rdy1), 32'(4'b0010));
        rv = 4'b1111; mr = 1'b0; addr[1] = 8'h44; wd[1] = 8'h11;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_mem_valid", 32'(s_mv1), 1);
            chk("bp_mem_addr",  32'(s_ma1), 32'h33);
            chk("bp_mem_wdata", 32'(s_mw1), 32'hC3);
            chk("bp_no_ready",  32'(s_rdy1), 0);
        end
        mr = 1'b1;
        step();
        chk("bp_accept_addr", 32'(s_ma1), 32'h33);
        chk("bp_accept_regrant", 32'(s_rdy1 != 0), 1);
        idle_cycles(5);

        // reset one cycle after a read accept
        addr[0] = 8'h05; op = '0; rv = 4'b0001; mr = 1'b1;
        step();
        rv = '0;
        step();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            rv = '0;
            step();
            chk("rstmid_no_rsp_L1", 32'(s_rsp1), 0);
        end
        rv = 4'b1111;
        step();
        chk("rstmid_ptr_restart", 32'(s_rdy1), 32'(4'b0001));
        idle_cycles(6);

        // READ_LAT=3 burst of four reads from requester 1
        first_acc = -1; first_rsp = -1; pulses = 0;
        op = '0; mr = 1'b1;
        for (int j = 0; j < 4; j++) begin
            addr[1] = 8'(8'h20 + j);
            rv = 4'b0010;
            if (j == 1) first_acc = cyc;
            step();
            if (s_rsp3 == 4'b0010) begin
                pulses++;
                if (first_rsp < 0) first_rsp = cyc - 1;
            end
        end
        rv = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (s_rsp3 == 4'b0010) begin
                pulses++;
                if (first_rsp < 0) first_rsp = cyc - 1;
            end
        end
        chk("lat3_pulses", 32'(pulses), 4);
        chk("lat3_first_delay", 32'(first_rsp - first_acc), 3);

        // randomized traffic with backpressure and small address space
        for (int c = 0; c < 1500; c++) begin
            rv = 4'($urandom_range(0, 15));
            op = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                addr[i] = 8'($urandom_range(0, 15));
                wd[i]   = 8'($urandom);
            end
            mr = ($urandom_range(0, 9) < 7);
            step();
        end
        idle_cycles(6);
        chk("drain_q1_empty", 32'(q1.size()), 0);
        chk("drain_q3_empty", 32'(q3.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
